// File: rtl/slot_state_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : slot_state_ctrl_if
// Purpose : Host configuration bus into the slot-state controller.
// Revision: 1.0
// ----------------------------------------------------------------------------
interface slot_state_ctrl_if #(
  parameter int AW = 10,
  parameter int DW = 14
);
  logic          cfg_req;
  logic          cfg_wr;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_wdata;
  logic          cfg_gnt;
  logic          cfg_rvalid;
  logic [DW-1:0] cfg_rdata;

  modport master (
    output cfg_req, cfg_wr, cfg_addr, cfg_wdata,
    input  cfg_gnt, cfg_rvalid, cfg_rdata
  );

  modport slave (
    input  cfg_req, cfg_wr, cfg_addr, cfg_wdata,
    output cfg_gnt, cfg_rvalid, cfg_rdata
  );
endinterface
`default_nettype wire

// File: rtl/slot_state_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : slot_state_ctrl
// Purpose : Owns the slot-state RAM port; arbitrates host access against a
//           per-frame read-modify-write aging sweep of every slot entry.
// Revision: 1.0
// ----------------------------------------------------------------------------
module slot_state_ctrl #(
  parameter int N_SLOTS = 10,
  parameter int AW      = 10,
  parameter int DW      = 14,
  parameter int LIFE_W  = 4
) (
  input  wire logic          clk,
  input  wire logic          rst,
  input  wire logic          frame_start_i,
  slot_state_ctrl_if.slave   cfg,
  output logic               ram_wen_o,
  output logic [AW-1:0]      ram_addr_o,
  output logic [DW-1:0]      ram_wdata_o,
  input  wire logic [DW-1:0] ram_rdata_i,
  output logic               sweep_busy_o,
  output logic               sweep_done_o,
  output logic               sweep_overrun_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SW_RD = 2'd1,
    SW_WB = 2'd2,
    CFG   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] slot_q, slot_d;
  logic          pending_q, pending_d;
  logic          busy_q, done_q, overrun_q, rvalid_q;

  logic              w_host;
  logic              w_last;
  logic [LIFE_W-1:0] w_life;
  logic [DW-1:0]     w_aged;

  assign w_host = cfg.cfg_req && (state_q == IDLE || state_q == CFG);
  assign w_last = (slot_q == AW'(N_SLOTS - 1));
  assign w_life = ram_rdata_i[LIFE_W-1:0];

  // Expired entries keep their node id so the host can still see who left.
  always_comb begin
    w_aged = ram_rdata_i;
    if (ram_rdata_i[DW-1]) begin
      if (w_life > LIFE_W'(1)) begin
        w_aged[LIFE_W-1:0] = w_life - LIFE_W'(1);
      end else begin
        w_aged[DW-1]       = 1'b0;
        w_aged[LIFE_W-1:0] = '0;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    slot_d    = slot_q;
    pending_d = pending_q;
    case (state_q)
      IDLE: begin
        if (cfg.cfg_req) begin
          if (frame_start_i) pending_d = 1'b1;
        end else if (frame_start_i || pending_q) begin
          state_d   = SW_RD;
          slot_d    = '0;
          pending_d = 1'b0;
        end
      end
      SW_RD: state_d = SW_WB;
      SW_WB: begin
        if (w_last) begin
          state_d = IDLE;
          slot_d  = '0;
        end else begin
          state_d = cfg.cfg_req ? CFG : SW_RD;
          slot_d  = slot_q + AW'(1);
        end
      end
      CFG:     state_d = SW_RD;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      slot_q    <= '0;
      pending_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      slot_q    <= slot_d;
      pending_q <= pending_d;
      busy_q    <= (state_d != IDLE);
      done_q    <= (state_q == SW_WB) && w_last;
      overrun_q <= frame_start_i && ((state_q != IDLE) || pending_q);
      rvalid_q  <= w_host && !cfg.cfg_wr;
    end
  end

  // RAM port mux: host address only in its granted cycle, sweep owns the rest.
  always_comb begin
    ram_wen_o   = 1'b0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (w_host) begin
      ram_wen_o  = cfg.cfg_wr;
      ram_addr_o = cfg.cfg_addr;
      if (cfg.cfg_wr) ram_wdata_o = cfg.cfg_wdata;
    end else if (state_q == SW_RD) begin
      ram_addr_o = slot_q;
    end else if (state_q == SW_WB) begin
      ram_wen_o   = 1'b1;
      ram_addr_o  = slot_q;
      ram_wdata_o = w_aged;
    end
  end

  assign cfg.cfg_gnt    = w_host;
  assign cfg.cfg_rvalid = rvalid_q;
  assign cfg.cfg_rdata  = rvalid_q ? ram_rdata_i : '0;

  assign sweep_busy_o    = busy_q;
  assign sweep_done_o    = done_q;
  assign sweep_overrun_o = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_slot_state_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module  : tb_slot_state_ctrl
// Purpose : Directed self-checking bench for slot_state_ctrl with a RAM model.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_slot_state_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic        ram_wen;
  logic [9:0]  ram_addr;
  logic [13:0] ram_wdata;
  logic [13:0] ram_rdata;
  logic        sweep_busy, sweep_done, sweep_overrun;

  logic [13:0] mem [0:1023] = '{default: 14'h0};

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0, ovr_cnt = 0, wb_cnt = 0, rd_cnt = 0, alt_bad = 0;
  logic prev_busy = 1'b0, prev_wen = 1'b0, gnt_after_wb = 1'b0;
  int g_cyc;

  slot_state_ctrl_if #(.AW(10), .DW(14)) cfg_if ();

  slot_state_ctrl #(.N_SLOTS(10), .AW(10), .DW(14), .LIFE_W(4)) u_dut (
    .clk             (clk),
    .rst             (rst),
    .frame_start_i   (frame_start),
    .cfg             (cfg_if),
    .ram_wen_o       (ram_wen),
    .ram_addr_o      (ram_addr),
    .ram_wdata_o     (ram_wdata),
    .ram_rdata_i     (ram_rdata),
    .sweep_busy_o    (sweep_busy),
    .sweep_done_o    (sweep_done),
    .sweep_overrun_o (sweep_overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_wen) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  always @(negedge clk) begin
    if (sweep_done)    done_cnt++;
    if (sweep_overrun) ovr_cnt++;
    if (sweep_busy) begin
      if (ram_wen) wb_cnt++; else rd_cnt++;
      if (prev_busy && (ram_wen == prev_wen)) alt_bad++;
    end
    if (cfg_if.cfg_gnt) gnt_after_wb = prev_busy && prev_wen;
    prev_busy = sweep_busy;
    prev_wen  = ram_wen;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_gnt(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (cfg_if.cfg_gnt) begin
        seen  = 1'b1;
        g_cyc = cyc;
        break;
      end
    end
    if (!seen) check_eq(tag, 32'd0, 32'd1);
  endtask

  task automatic host_write(input logic [9:0] a, input logic [13:0] d);
    @(posedge clk); #1;
    cfg_if.cfg_req   = 1'b1;
    cfg_if.cfg_wr    = 1'b1;
    cfg_if.cfg_addr  = a;
    cfg_if.cfg_wdata = d;
    wait_gnt("wr_gnt_timeout");
    @(posedge clk); #1;
    cfg_if.cfg_req = 1'b0;
    cfg_if.cfg_wr  = 1'b0;
    @(negedge clk);
    check_eq("wr_no_rvalid", 32'(cfg_if.cfg_rvalid), 32'd0);
  endtask

  task automatic host_read(input logic [9:0] a, output logic [13:0] d);
    @(posedge clk); #1;
    cfg_if.cfg_req  = 1'b1;
    cfg_if.cfg_wr   = 1'b0;
    cfg_if.cfg_addr = a;
    wait_gnt("rd_gnt_timeout");
    @(posedge clk); #1;
    cfg_if.cfg_req = 1'b0;
    @(negedge clk);
    check_eq("rd_rvalid", 32'(cfg_if.cfg_rvalid), 32'd1);
    d = cfg_if.cfg_rdata;
  endtask

  task automatic read_check(input string tag, input logic [9:0] a, input logic [13:0] exp);
    logic [13:0] d;
    host_read(a, d);
    check_eq(tag, 32'(d), 32'(exp));
  endtask

  task automatic pulse_frame(output int t0);
    @(posedge clk); #1;
    frame_start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic wait_done(output int dc);
    dc = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (sweep_done) begin
        dc = cyc;
        break;
      end
    end
    if (dc < 0) check_eq("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int t0, dc, b_done, b_ovr, b_wb, b_rd, b_alt;
    logic [13:0] d;
    rst              = 1'b1;
    frame_start      = 1'b0;
    cfg_if.cfg_req   = 1'b0;
    cfg_if.cfg_wr    = 1'b0;
    cfg_if.cfg_addr  = '0;
    cfg_if.cfg_wdata = '0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_wen",    32'(ram_wen),             32'd0);
    check_eq("rst_busy",   32'(sweep_busy),          32'd0);
    check_eq("rst_done",   32'(sweep_done),          32'd0);
    check_eq("rst_gnt",    32'(cfg_if.cfg_gnt),      32'd0);
    check_eq("rst_rvalid", 32'(cfg_if.cfg_rvalid),   32'd0);
    check_eq("rst_rdata",  32'(cfg_if.cfg_rdata),    32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_busy", 32'(sweep_busy), 32'd0);

    // T1: single sweep, no host traffic
    host_write(10'd3, 14'h2005);
    b_done = done_cnt; b_wb = wb_cnt; b_rd = rd_cnt; b_alt = alt_bad;
    pulse_frame(t0);
    wait_done(dc);
    check_eq("t1_done_cyc", 32'(dc), 32'(t0 + 21));
    @(posedge clk); #1;
    check_eq("t1_wr_cycles", 32'(wb_cnt - b_wb),   32'd10);
    check_eq("t1_rd_cycles", 32'(rd_cnt - b_rd),   32'd10);
    check_eq("t1_alternate", 32'(alt_bad - b_alt), 32'd0);
    check_eq("t1_one_done",  32'(done_cnt - b_done), 32'd1);
    read_check("t1_slot3", 10'd3, 14'h2004);

    // T2: expiry and invalid entries
    host_write(10'd0, 14'h3FF1);
    host_write(10'd1, 14'h1FF7);
    pulse_frame(t0);
    wait_done(dc);
    check_eq("t2_done_cyc", 32'(dc), 32'(t0 + 21));
    read_check("t2_slot0", 10'd0, 14'h1FF0);
    read_check("t2_slot1", 10'd1, 14'h1FF7);
    read_check("t2_slot3", 10'd3, 14'h2003);

    // T3: host read interleaved with a sweep
    host_write(10'd7, 14'h2A09);
    pulse_frame(t0);
    @(posedge clk);
    host_read(10'd7, d);
    check_eq("t3_gnt_cyc",   32'(g_cyc), 32'(t0 + 5));
    check_eq("t3_after_wb",  32'(gnt_after_wb), 32'd1);
    check_eq("t3_rdata",     32'(d), 32'h2A09);
    wait_done(dc);
    check_eq("t3_done_cyc", 32'(dc), 32'(t0 + 22));
    read_check("t3_slot7", 10'd7, 14'h2A08);

    // T4: frame_start coincident with a host write in IDLE
    @(posedge clk); #1;
    frame_start      = 1'b1;
    cfg_if.cfg_req   = 1'b1;
    cfg_if.cfg_wr    = 1'b1;
    cfg_if.cfg_addr  = 10'd2;
    cfg_if.cfg_wdata = 14'h2003;
    t0 = cyc;
    @(negedge clk);
    check_eq("t4_gnt",  32'(cfg_if.cfg_gnt), 32'd1);
    check_eq("t4_busy0", 32'(sweep_busy),    32'd0);
    @(posedge clk); #1;
    frame_start    = 1'b0;
    cfg_if.cfg_req = 1'b0;
    cfg_if.cfg_wr  = 1'b0;
    wait_done(dc);
    check_eq("t4_done_cyc", 32'(dc), 32'(t0 + 22));
    read_check("t4_slot2", 10'd2, 14'h2002);

    // T5: overrun during a sweep
    host_write(10'd5, 14'h2006);
    b_done = done_cnt; b_ovr = ovr_cnt;
    pulse_frame(t0);
    repeat (4) @(posedge clk);
    #1;
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
    wait_done(dc);
    check_eq("t5_done_cyc", 32'(dc), 32'(t0 + 21));
    repeat (30) @(posedge clk);
    #1;
    check_eq("t5_one_done", 32'(done_cnt - b_done), 32'd1);
    check_eq("t5_overrun",  32'(ovr_cnt - b_ovr),   32'd1);
    read_check("t5_slot5", 10'd5, 14'h2005);
    read_check("t5_slot7", 10'd7, 14'h2A06);

    // T6: reset during write-back of slot 4
    host_write(10'd4, 14'h2008);
    b_done = done_cnt;
    pulse_frame(t0);
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("t6_wen_now",  32'(ram_wen),    32'd0);
    check_eq("t6_busy_now", 32'(sweep_busy), 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check_eq("t6_no_done", 32'(done_cnt - b_done), 32'd0);
    read_check("t6_slot4_kept", 10'd4, 14'h2008);
    pulse_frame(t0);
    @(negedge clk);
    check_eq("t6_first_addr", 32'(ram_addr), 32'd0);
    check_eq("t6_first_rd",   32'(ram_wen),  32'd0);
    wait_done(dc);
    check_eq("t6_done_cyc", 32'(dc), 32'(t0 + 21));
    read_check("t6_slot4", 10'd4, 14'h2007);
    read_check("t6_slot5", 10'd5, 14'h2004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
